// File: rtl/block_check_arbiter.sv
// ---------------------------------------------------------------------------
// block_check_arbiter
//
// Shares a single BlockChecker between two character-stream requesters, one
// complete session at a time. A session is: grant, one clear cycle to the
// checker, stream characters (one per cycle), let the checker absorb the last
// character, then capture the verdict into that requester's result register
// and rearbitrate round-robin.
//
// Handshake: a character moves on a rising edge where reqN_valid and
// reqN_ready are both high. reqN_ready is decoded from registered state only
// (STREAM and granted to N), so it never depends on reqN_valid. A requester
// keeps valid/char/last stable until that edge; dropping valid between
// characters simply stalls the session.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   reqN_valid/char/last  requester N character offer (N = 0, 1)
//   reqN_ready            requester N character accepted this cycle
//   chk_clr               one-cycle synchronous clear to the checker
//   chk_in, chk_en        character to the checker and its clock enable
//   chk_result            checker verdict (1 = begin/end balanced)
//   grant                 one-hot current owner, 00 between sessions
//   busy                  a session is in progress
//   doneN                 one-cycle pulse, session for N completed
//   resultN, truncN       last captured verdict / truncation flag for N
//   dbg_state             current FSM state (IDLE=0 CLEAR=1 STREAM=2
//                         WAIT=3 SAMPLE=4)
// ---------------------------------------------------------------------------
module block_check_arbiter #(
    parameter int CHAR_W  = 8,
    parameter int MAX_LEN = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [CHAR_W-1:0] req0_char,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [CHAR_W-1:0] req1_char,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              chk_clr,
    output logic [CHAR_W-1:0] chk_in,
    output logic              chk_en,
    input  logic              chk_result,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              done0,
    output logic              done1,
    output logic              result0,
    output logic              result1,
    output logic              trunc0,
    output logic              trunc1,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_SAMPLE = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              ptr_q, ptr_d;          // 1: requester 1 wins a tie
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tflag_q, tflag_d;      // current session hit MAX_LEN
    logic [CHAR_W-1:0] chk_in_q, chk_in_d;
    logic              chk_en_q, chk_en_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              result0_q, result0_d, result1_q, result1_d;
    logic              trunc0_q, trunc0_d, trunc1_q, trunc1_d;

    logic              xfer;
    logic [CHAR_W-1:0] xfer_char;
    logic              xfer_last;
    logic              at_max;

    assign xfer      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign xfer_char = grant_q[1] ? req1_char : req0_char;
    assign xfer_last = grant_q[1] ? req1_last : req0_last;
    // The character being accepted now is the MAX_LEN-th of the session.
    assign at_max    = (cnt_q == CNT_W'(MAX_LEN - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q   <= 2'b00;
            ptr_q     <= 1'b0;
            cnt_q     <= '0;
            tflag_q   <= 1'b0;
            chk_in_q  <= '0;
            chk_en_q  <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            result0_q <= 1'b0;
            result1_q <= 1'b0;
            trunc0_q  <= 1'b0;
            trunc1_q  <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tflag_q   <= tflag_d;
            chk_in_q  <= chk_in_d;
            chk_en_q  <= chk_en_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            result0_q <= result0_d;
            result1_q <= result1_d;
            trunc0_q  <= trunc0_d;
            trunc1_q  <= trunc1_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tflag_d   = tflag_q;
        chk_in_d  = chk_in_q;
        chk_en_d  = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        result0_d = result0_q;
        result1_d = result1_q;
        trunc0_d  = trunc0_q;
        trunc1_d  = trunc1_q;

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        grant_d = ptr_q ? 2'b10 : 2'b01;
                    end else begin
                        grant_d = req1_valid ? 2'b10 : 2'b01;
                    end
                    cnt_d   = '0;
                    tflag_d = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (xfer) begin
                    chk_in_d = xfer_char;
                    chk_en_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (xfer_last) begin
                        state_d = S_WAIT;
                    end else if (at_max) begin
                        // Cut the session; the rest arrives as a new one.
                        tflag_d = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // chk_en_q is still high here, carrying the final character.
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (grant_q[0]) begin
                    result0_d = tflag_q ? 1'b0 : chk_result;
                    trunc0_d  = tflag_q;
                    done0_d   = 1'b1;
                end
                if (grant_q[1]) begin
                    result1_d = tflag_q ? 1'b0 : chk_result;
                    trunc1_d  = tflag_q;
                    done1_d   = 1'b1;
                end
                // Favour whichever requester was not just served.
                ptr_d   = grant_q[0];
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        req0_ready = (state_q == S_STREAM) && grant_q[0];
        req1_ready = (state_q == S_STREAM) && grant_q[1];
        chk_clr    = (state_q == S_CLEAR);
        busy       = (state_q != S_IDLE);
        grant      = grant_q;
        dbg_state  = state_q;
        chk_in     = chk_in_q;
        chk_en     = chk_en_q;
        done0      = done0_q;
        done1      = done1_q;
        result0    = result0_q;
        result1    = result1_q;
        trunc0     = trunc0_q;
        trunc1     = trunc1_q;
    end

endmodule

// File: tb/tb_block_check_arbiter.sv
module tb_block_check_arbiter;
  localparam int CHAR_W  = 8;
  localparam int MAX_LEN = 12;
  localparam int CNT_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              req0_valid = 1'b0, req0_last = 1'b0;
  logic [CHAR_W-1:0] req0_char = '0;
  logic              req1_valid = 1'b0, req1_last = 1'b0;
  logic [CHAR_W-1:0] req1_char = '0;
  logic              req0_ready, req1_ready;
  logic              chk_clr, chk_en, busy;
  logic [CHAR_W-1:0] chk_in;
  logic              chk_result = 1'b1;
  logic [1:0]        grant;
  logic              done0, done1, result0, result1, trunc0, trunc1;
  logic [2:0]        dbg_state;

  block_check_arbiter #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_char(req0_char), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_char(req1_char), .req1_last(req1_last), .req1_ready(req1_ready),
    .chk_clr(chk_clr), .chk_in(chk_in), .chk_en(chk_en), .chk_result(chk_result),
    .grant(grant), .busy(busy), .done0(done0), .done1(done1),
    .result0(result0), .result1(result1), .trunc0(trunc0), .trunc1(trunc1),
    .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // Begin/end balance over space-separated words: every "end" needs an open
  // "begin", and nothing may be left open.
  function automatic bit balanced(input logic [7:0] b[$]);
    int depth = 0;
    bit err = 1'b0;
    logic [39:0] w = '0;
    int wl = 0;
    for (int i = 0; i <= b.size(); i++) begin
      if (i < b.size() && b[i] != 8'h20) begin
        w = {w[31:0], b[i]};
        wl++;
      end else begin
        if (wl == 5 && w == "begin") depth++;
        else if (wl == 3 && w[23:0] == "end") begin
          if (depth == 0) err = 1'b1;
          else depth--;
        end
        w = '0;
        wl = 0;
      end
    end
    return !err && depth == 0;
  endfunction

  // ---------------- checker model ----------------
  logic [7:0] chk_buf[$];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_buf.delete();
      chk_result <= 1'b1;
    end else if (chk_clr) begin
      chk_buf.delete();
      chk_result <= 1'b1;
    end else if (chk_en) begin
      chk_buf.push_back(chk_in);
      chk_result <= balanced(chk_buf);
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] sess[2][$];        // session being driven by requester n
  logic [7:0] exp_q[2][$];       // expected forwarded characters
  logic [5:0] exp_meta[2][$];    // {result, trunc, length} per expected session
  logic [7:0] cap[$];            // characters seen on chk_in this session
  int         done_order[$];
  int         clr_cnt = 0;
  logic       prev_clr = 1'b0;
  logic [1:0] grant_seen = 2'b00;

  task automatic score(input int n);
    logic [5:0] m;
    logic [7:0] e;
    int len;
    done_order.push_back(n);
    n_vec++;
    if (exp_meta[n].size() == 0) begin
      n_err++;
      $display("FAIL done_expected: requester %0d pulsed done, no session outstanding (t=%0t)", n, $time);
      return;
    end
    m = exp_meta[n].pop_front();
    len = int'(m[3:0]);
    check("result", (n == 0) ? result0 : result1, m[5]);
    check("trunc", (n == 0) ? trunc0 : trunc1, m[4]);
    check("fwd_len", cap.size(), len);
    for (int i = 0; i < len; i++) begin
      e = exp_q[n].pop_front();
      if (i < cap.size()) check("fwd_char", cap[i], e);
    end
    check("session_grant", grant_seen, 2'b01 << n);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      cap.delete();
      prev_clr = 1'b0;
    end else begin
      if (chk_clr) begin
        check("clr_single", {prev_clr, req1_ready, req0_ready, chk_en}, 4'b0);
        clr_cnt++;
        cap.delete();
        grant_seen = 2'b00;
      end
      prev_clr = chk_clr;
      grant_seen |= grant;
      if (req0_ready || req1_ready) check("ready_vs_grant", {req1_ready, req0_ready}, grant);
      if (chk_en) cap.push_back(chk_in);
      if (done0) score(0);
      if (done1) score(1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int n, input logic v, input logic [7:0] c, input logic l);
    if (n == 0) begin req0_valid = v; req0_char = c; req0_last = l; end
    else        begin req1_valid = v; req1_char = c; req1_last = l; end
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? req0_ready : req1_ready;
  endfunction

  // Called at a falling edge with valid already driven; returns at the
  // falling edge after the accepting rising edge.
  task automatic wait_xfer(input int n);
    int t = 0;
    while (!rdy(n)) begin
      @(negedge clk);
      t++;
      if (t > 3000) begin
        n_vec++; n_err++;
        $display("FAIL xfer_timeout: requester %0d never saw ready", n);
        finish_run();
      end
    end
    @(negedge clk);
  endtask

  task automatic load(input int n, input logic [8*24-1:0] txt, input int len);
    sess[n].delete();
    for (int i = len - 1; i >= 0; i--) sess[n].push_back(txt[8*i +: 8]);
  endtask

  task automatic push_exp(input int n, input int a, input int len, input logic res, input logic tr);
    for (int i = a; i < a + len; i++) exp_q[n].push_back(sess[n][i]);
    exp_meta[n].push_back({res, tr, 4'(len)});
  endtask

  task automatic send_session(input int n, input int gap_max);
    for (int i = 0; i < sess[n].size(); i++) begin
      if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
        set_req(n, 1'b0, 8'h00, 1'b0);
        repeat ($urandom_range(1, gap_max)) @(negedge clk);
      end
      set_req(n, 1'b1, sess[n][i], i == sess[n].size() - 1);
      wait_xfer(n);
    end
    set_req(n, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while ((exp_meta[0].size() != 0 || exp_meta[1].size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("drain", exp_meta[0].size() + exp_meta[1].size(), 0);
  endtask

  // Reference: a stream is cut into MAX_LEN pieces; a piece is truncated when
  // more characters follow it, and a truncated piece always reports 0.
  task automatic model_push(input int n);
    logic [7:0] chunk[$];
    int L, len;
    logic tr;
    L = sess[n].size();
    for (int a = 0; a < L; a += MAX_LEN) begin
      len = (L - a > MAX_LEN) ? MAX_LEN : L - a;
      tr = (a + MAX_LEN < L);
      chunk.delete();
      for (int i = a; i < a + len; i++) chunk.push_back(sess[n][i]);
      push_exp(n, a, len, tr ? 1'b0 : balanced(chunk), tr);
    end
  endtask

  task automatic push_word(input int n, input logic [39:0] wd, input int wl);
    for (int i = wl - 1; i >= 0; i--) sess[n].push_back(wd[8*i +: 8]);
  endtask

  task automatic gen_sess(input int n);
    int nw;
    nw = $urandom_range(1, 6);
    sess[n].delete();
    for (int w = 0; w < nw; w++) begin
      if (w > 0) sess[n].push_back(8'h20);
      case ($urandom_range(0, 4))
        0, 1:    push_word(n, "begin", 5);
        2, 3:    push_word(n, "end", 3);
        default: push_word(n, "x", 1);
      endcase
    end
    // Keep clear of a final piece of exactly MAX_LEN characters.
    if (sess[n].size() % MAX_LEN == 0) push_word(n, " x", 2);
  endtask

  task automatic rand_driver(input int n, input int k);
    for (int s = 0; s < k; s++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      gen_sess(n);
      model_push(n);
      send_session(n, 3);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int               req;
    logic [8*24-1:0]  txt;
    int               len;
    logic             res;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #500000;
    n_vec++; n_err++;
    $display("FAIL watchdog: run did not complete");
    finish_run();
  end

  initial begin
    int clr_before;

    tbl[0] = '{req: 0, txt: "begin end",   len: 9,  res: 1'b1};
    tbl[1] = '{req: 1, txt: "end begin",   len: 9,  res: 1'b0};
    tbl[2] = '{req: 1, txt: "begin end",   len: 9,  res: 1'b1};
    tbl[3] = '{req: 1, txt: "begin",       len: 5,  res: 1'b0};
    tbl[4] = '{req: 1, txt: "end",         len: 3,  res: 1'b0};
    tbl[5] = '{req: 0, txt: "x",           len: 1,  res: 1'b1};
    tbl[6] = '{req: 0, txt: "begin x end", len: 11, res: 1'b1};
    tbl[7] = '{req: 1, txt: "ab begin",    len: 8,  res: 1'b0};
    tbl[8] = '{req: 0, txt: "begin  end",  len: 10, res: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs", {grant, busy, chk_clr, chk_en, chk_in, done0, done1, result0, result1,
                         trunc0, trunc1, req0_ready, req1_ready}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outs", {grant, busy, chk_clr, chk_en, req0_ready, req1_ready}, 32'h0);

    // Single session with latency checks
    clr_before = clr_cnt;
    load(0, "begin end", 9);
    push_exp(0, 0, 9, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      set_req(0, 1'b1, sess[0][i], i == 8);
      wait_xfer(0);
      if (i == 0) check("first_grant", {grant, busy}, 3'b011);
    end
    set_req(0, 1'b0, 8'h00, 1'b0);
    check("wait_cycle", {chk_en, chk_in, busy, req0_ready}, {1'b1, 8'h64, 1'b1, 1'b0});
    @(negedge clk);
    check("sample_cycle", {done0, chk_en, busy}, 3'b001);
    @(negedge clk);
    check("done_cycle", {done0, done1, grant, busy}, 5'b10000);
    @(negedge clk);
    check("done_one_pulse", {done0, result0, trunc0}, 3'b010);
    check("clr_per_session", clr_cnt - clr_before, 1);

    // Table-driven single-requester sessions
    for (int v = 0; v < 9; v++) begin
      clr_before = clr_cnt;
      load(tbl[v].req, tbl[v].txt, tbl[v].len);
      push_exp(tbl[v].req, 0, tbl[v].len, tbl[v].res, 1'b0);
      send_session(tbl[v].req, 0);
      wait_drain(100);
      check("clr_per_session", clr_cnt - clr_before, 1);
    end

    // Reset clears results; then both requesters valid in the same cycle
    reset = 1'b0;
    @(negedge clk);
    check("reset_results", {result0, result1, trunc0, trunc1, done0, done1}, 6'b0);
    reset = 1'b1;
    @(negedge clk);
    load(0, "begin", 5);
    load(1, "end", 3);
    push_exp(0, 0, 5, 1'b0, 1'b0);
    push_exp(1, 0, 3, 1'b0, 1'b0);
    done_order.delete();
    fork
      send_session(0, 0);
      send_session(1, 0);
    join
    wait_drain(100);
    check("arb_count", done_order.size(), 2);
    if (done_order.size() == 2) begin
      check("arb_first", done_order[0], 0);
      check("arb_second", done_order[1], 1);
    end

    // Mid-word stall of five cycles
    load(0, "begin end", 9);
    push_exp(0, 0, 9, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      set_req(0, 1'b1, sess[0][i], i == 8);
      wait_xfer(0);
      if (i == 2) begin
        set_req(0, 1'b0, 8'h00, 1'b0);
        repeat (5) begin
          @(negedge clk);
          check("stall", {chk_en, chk_in, busy}, {1'b0, 8'h67, 1'b1});
        end
      end
    end
    set_req(0, 1'b0, 8'h00, 1'b0);
    wait_drain(100);

    // Truncation at MAX_LEN, remainder becomes its own session
    load(0, "begin begin end end", 19);
    push_exp(0, 0, 12, 1'b0, 1'b1);
    push_exp(0, 12, 7, 1'b0, 1'b0);
    send_session(0, 0);
    wait_drain(100);

    // Randomised traffic from both requesters
    fork
      rand_driver(0, 12);
      rand_driver(1, 12);
    join
    wait_drain(400);

    // Reset in the middle of a requester 1 session
    load(1, "begin end", 9);
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1'b1, sess[1][i], 1'b0);
      wait_xfer(1);
    end
    #2;
    reset = 1'b0;
    #1;
    check("abort_outs", {grant, busy, chk_clr, chk_en, chk_in, done0, done1, result0, result1,
                         trunc0, trunc1, req0_ready, req1_ready}, 32'h0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_idle", {busy, grant, done1}, 4'b0);
    clr_before = clr_cnt;
    load(1, "begin end", 9);
    push_exp(1, 0, 9, 1'b1, 1'b0);
    send_session(1, 0);
    wait_drain(100);
    check("clr_after_abort", clr_cnt - clr_before, 1);

    finish_run();
  end
endmodule
